settings_bus_demux: RTL and testbench

- Single-clock settings-bus demultiplexer: the fan-out counterpart to the settings-bus mux.
- Takes one flow-controlled settings bus and routes each write to one of NUM_BUSES output buses. The target port is decoded from the upper address bits.
- Each output port has a 2-entry FIFO, so a stalled consumer does not block writes to other ports.
- Sits between a host-side settings master (e.g. a crossbar control port) and per-block settings consumers.

---
 rtl/settings_bus_demux_if.sv | 28 ++
 rtl/settings_bus_demux.sv | 132 +++++++++++++
 tb/tb_settings_bus_demux.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/settings_bus_demux_if.sv
// Settings-bus demux port bundle: one upstream write bus plus NUM_BUSES downstream buses.
// master = host/test side driving writes and consumer readies; slave = the demux.
interface settings_bus_demux_if #(
  parameter int AWIDTH    = 8,
  parameter int DWIDTH    = 32,
  parameter int SEL_WIDTH = 1,
  parameter int NUM_BUSES = 2
);
  logic                                      in_set_stb;
  logic [AWIDTH-1:0]                         in_set_addr;
  logic [DWIDTH-1:0]                         in_set_data;
  logic                                      in_set_ready;
  logic [NUM_BUSES-1:0]                      out_set_stb;
  logic [NUM_BUSES*(AWIDTH-SEL_WIDTH)-1:0]   out_set_addr;
  logic [NUM_BUSES*DWIDTH-1:0]               out_set_data;
  logic [NUM_BUSES-1:0]                      out_set_ready;
  logic [15:0]                               drop_count;

  modport master (
    output in_set_stb, in_set_addr, in_set_data, out_set_ready,
    input  in_set_ready, out_set_stb, out_set_addr, out_set_data, drop_count
  );

  modport slave (
    input  in_set_stb, in_set_addr, in_set_data, out_set_ready,
    output in_set_ready, out_set_stb, out_set_addr, out_set_data, drop_count
  );
endinterface

// File: rtl/settings_bus_demux.sv
// Settings-bus demux: routes each write by its upper SEL_WIDTH address bits into a 2-deep per-port FIFO.
// Optional macro SETTINGS_DEMUX_DROP_CNT_EN adds a saturating counter of unmapped writes on drop_count.
module settings_bus_demux #(
  parameter int AWIDTH    = 8,
  parameter int DWIDTH    = 32,
  parameter int SEL_WIDTH = 1,
  parameter int NUM_BUSES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  settings_bus_demux_if.slave  bus
);
  localparam int OAW = AWIDTH - SEL_WIDTH;

  logic [SEL_WIDTH-1:0]          sel;
  logic [OAW-1:0]                strip_addr;
  logic                          mapped;
  logic                          in_rdy;
  logic                          accept;
  logic                          rdy_en_q;
  logic [NUM_BUSES-1:0]          hit;
  logic [NUM_BUSES-1:0]          full;
  logic [NUM_BUSES-1:0]          nonempty;
  logic [OAW-1:0]                head_addr [NUM_BUSES];
  logic [DWIDTH-1:0]             head_data [NUM_BUSES];
  logic [NUM_BUSES*OAW-1:0]      out_addr;
  logic [NUM_BUSES*DWIDTH-1:0]   out_data;

  assign sel        = bus.in_set_addr[AWIDTH-1 -: SEL_WIDTH];
  assign strip_addr = bus.in_set_addr[OAW-1:0];
  // A write is mapped exactly when one of the implemented ports decodes it.
  assign mapped     = |hit;
  assign in_rdy     = rdy_en_q & (~mapped | ~(|(hit & full)));
  assign accept     = bus.in_set_stb & in_rdy;

  assign bus.in_set_ready = in_rdy;
  assign bus.out_set_stb  = nonempty;
  assign bus.out_set_addr = out_addr;
  assign bus.out_set_data = out_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_BUSES; g++) begin : g_port
    localparam logic [SEL_WIDTH-1:0] IDX = SEL_WIDTH'(g);

    logic [OAW-1:0]    addr_mem_q [2];
    logic [DWIDTH-1:0] data_mem_q [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              push, pop;

    assign hit[g]      = (sel == IDX);
    assign full[g]     = (cnt_q == 2'd2);
    assign nonempty[g] = (cnt_q != 2'd0);
    assign push        = accept & hit[g];
    assign pop         = nonempty[g] & bus.out_set_ready[g];

    always_comb begin
      wr_ptr_d = wr_ptr_q ^ push;
      rd_ptr_d = rd_ptr_q ^ pop;
      cnt_d    = cnt_q;
      if (push && !pop) begin
        cnt_d = cnt_q + 2'd1;
      end else if (pop && !push) begin
        cnt_d = cnt_q - 2'd1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr_q      <= 1'b0;
        rd_ptr_q      <= 1'b0;
        cnt_q         <= 2'd0;
        addr_mem_q[0] <= '0;
        addr_mem_q[1] <= '0;
        data_mem_q[0] <= '0;
        data_mem_q[1] <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        cnt_q    <= cnt_d;
        if (push) begin
          addr_mem_q[wr_ptr_q] <= strip_addr;
          data_mem_q[wr_ptr_q] <= bus.in_set_data;
        end
      end
    end

    assign head_addr[g] = addr_mem_q[rd_ptr_q];
    assign head_data[g] = data_mem_q[rd_ptr_q];
  end

  always_comb begin
    out_addr = '0;
    out_data = '0;
    for (int i = 0; i < NUM_BUSES; i++) begin
      out_addr[i*OAW +: OAW]       = head_addr[i];
      out_data[i*DWIDTH +: DWIDTH] = head_data[i];
    end
  end

`ifdef SETTINGS_DEMUX_DROP_CNT_EN
  logic [15:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (accept && !mapped && drop_q != 16'hFFFF) begin
      drop_d = drop_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= 16'd0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign bus.drop_count = drop_q;
`else
  assign bus.drop_count = 16'd0;
`endif

endmodule

// File: tb/tb_settings_bus_demux.sv
// Bench for settings_bus_demux (3 ports, 2 select bits): directed cases plus random traffic vs. a queue model.
module tb_settings_bus_demux;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int SW = 2;
  localparam int NB = 3;
  localparam int OAW = AW - SW;
`ifdef SETTINGS_DEMUX_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  typedef struct packed {
    logic [OAW-1:0] a;
    logic [DW-1:0]  d;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_bad = 0;
  ent_t mq [NB][$];
  int   mdrop = 0;

  settings_bus_demux_if #(.AWIDTH(AW), .DWIDTH(DW), .SEL_WIDTH(SW), .NUM_BUSES(NB)) bus ();

  settings_bus_demux #(.AWIDTH(AW), .DWIDTH(DW), .SEL_WIDTH(SW), .NUM_BUSES(NB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge; drives one cycle, checks against the model, advances to the next negedge.
  task automatic step(input logic stb, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [NB-1:0] rdy);
    logic [SW-1:0] s;
    logic          exp_rdy;
    bus.in_set_stb    = stb;
    bus.in_set_addr   = a;
    bus.in_set_data   = d;
    bus.out_set_ready = rdy;
    #1;
    s = a[AW-1 -: SW];
    if (int'(s) >= NB) exp_rdy = 1'b1;
    else               exp_rdy = (mq[s].size() < 2);
    chk("in_rdy", bus.in_set_ready, exp_rdy);
    for (int i = 0; i < NB; i++) begin
      chk("out_stb", bus.out_set_stb[i], mq[i].size() != 0);
      if (mq[i].size() != 0) begin
        chk("out_addr", bus.out_set_addr[i*OAW +: OAW], mq[i][0].a);
        chk("out_data", bus.out_set_data[i*DW +: DW], mq[i][0].d);
      end
    end
    chk("drop", bus.drop_count, mdrop);
    @(posedge clk);
    for (int i = 0; i < NB; i++) begin
      if (rdy[i] && mq[i].size() != 0) void'(mq[i].pop_front());
    end
    if (stb && exp_rdy) begin
      if (int'(s) < NB) mq[s].push_back({a[OAW-1:0], d});
      else if (DROP_EN && mdrop < 65535) mdrop++;
    end
    @(negedge clk);
  endtask

  task automatic chk_reset_vals();
    chk("rst_stb", bus.out_set_stb, '0);
    chk("rst_rdy", bus.in_set_ready, 1'b0);
    chk("rst_addr", bus.out_set_addr, '0);
    chk("rst_data", bus.out_set_data, '0);
    chk("rst_drop", bus.drop_count, 16'd0);
  endtask

  initial begin
    int n_sat;
    bus.in_set_stb    = 1'b0;
    bus.in_set_addr   = '0;
    bus.in_set_data   = '0;
    bus.out_set_ready = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Routing: 0x85 -> port 2 stripped 0x05, one cycle wide.
    step(1'b1, 8'h85, 32'hDEADBEEF, 3'b111);
    chk("route_stb", bus.out_set_stb, 3'b100);
    chk("route_addr", bus.out_set_addr[2*OAW +: OAW], 6'h05);
    chk("route_data", bus.out_set_data[2*DW +: DW], 32'hDEADBEEF);
    step(1'b1, 8'h12, 32'h1, 3'b111);
    chk("route_stb1", bus.out_set_stb, 3'b001);
    chk("route_addr0", bus.out_set_addr[0 +: OAW], 6'h12);
    step(1'b0, 8'h00, 32'h0, 3'b111);
    chk("route_idle", bus.out_set_stb, 3'b000);

    // Backpressure on port 0; port 1 keeps flowing.
    step(1'b1, 8'h01, 32'd1, 3'b110);
    step(1'b1, 8'h02, 32'd2, 3'b110);
    bus.in_set_addr = 8'h03;
    #1;
    chk("bp_full", bus.in_set_ready, 1'b0);
    step(1'b1, 8'h03, 32'd3, 3'b110);
    step(1'b1, 8'h4A, 32'hAA, 3'b110);
    chk("bp_p1", bus.out_set_stb, 3'b011);
    step(1'b1, 8'h03, 32'd3, 3'b111);
    step(1'b1, 8'h03, 32'd3, 3'b111);
    step(1'b0, 8'h00, 32'd0, 3'b111);
    step(1'b0, 8'h00, 32'd0, 3'b111);

    // Push and pop on the same port in one cycle: no bubble.
    step(1'b1, 8'h01, 32'hA, 3'b111);
    step(1'b1, 8'h02, 32'hB, 3'b111);
    chk("pp_stb", bus.out_set_stb[0], 1'b1);
    chk("pp_data", bus.out_set_data[0 +: DW], 32'hB);
    step(1'b0, 8'h00, 32'h0, 3'b111);
    chk("pp_empty", bus.out_set_stb[0], 1'b0);

    // Unmapped write: accepted, never delivered.
    step(1'b1, 8'hC0, 32'h55, 3'b111);
    chk("unm_stb", bus.out_set_stb, 3'b000);
    chk("unm_drop", bus.drop_count, DROP_EN ? 16'd1 : 16'd0);

    // Drop counter saturation (long run only when the counter exists).
    n_sat = DROP_EN ? 70000 : 200;
    bus.in_set_stb  = 1'b1;
    bus.in_set_addr = 8'hC0;
    repeat (n_sat) @(posedge clk);
    @(negedge clk);
    bus.in_set_stb = 1'b0;
    mdrop = DROP_EN ? ((mdrop + n_sat > 65535) ? 65535 : mdrop + n_sat) : 0;
    chk("drop_sat", bus.drop_count, DROP_EN ? 16'hFFFF : 16'h0000);

    // Randomized traffic against the queue model.
    for (int k = 0; k < 3000; k++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), $urandom, 3'($urandom_range(0, 7)));
    end

    // Reset in the middle of traffic.
    step(1'b1, 8'h07, 32'h70, 3'b000);
    step(1'b1, 8'h08, 32'h80, 3'b000);
    step(1'b1, 8'h49, 32'h90, 3'b000);
    step(1'b1, 8'h8A, 32'hA0, 3'b000);
    chk("mid_full", bus.out_set_stb, 3'b111);
    bus.in_set_stb = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    for (int i = 0; i < NB; i++) mq[i].delete();
    mdrop = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) step(1'b0, 8'h00, 32'h0, 3'b111);
    chk("post_rst", bus.out_set_stb, 3'b000);
    for (int k = 0; k < 200; k++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), $urandom, 3'($urandom_range(0, 7)));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
